mem_load_align: RTL
===================

# mem_load_align

Load-response side of the data-memory interface. Tracks the metadata of outstanding load requests, such as byte offset, access width, signedness and destination tag, in an in-order FIFO. When the word-granular memory response arrives, the block extracts the addressed byte, halfword or word, sign- or zero-extends it to 32 bits, and delivers it to writeback one cycle later. It sits between the memory interface read-data return and the pipeline writeback stage, mirroring the request-side word-address/strobe generation.

## Interface
- `DEPTH`, default 4: maximum outstanding loads. Must be a power of 2 and at least 2.
- `TAG_W`, default 5: width of the destination tag (register index).

- `clk_i` input, 1: clock, rising edge.
- `rstn_i` input, 1: reset, asynchronous, active-low.
- `req_valid_i` input, 1: a load request is issued to memory this cycle.
- `req_width_i` input, `mem_width_e`: `BYTE` / `HALF` / `WORD`.
- `req_unsigned_i` input, 1: 1 means zero-extend, 0 means sign-extend.
- `req_byte_idx_i` input, 2: byte address bits [1:0] of the load.
- `req_tag_i` input, `TAG_W`: destination tag.
- `req_ready_o` output, 1: FIFO can accept a request. Equal to `pending_o != DEPTH`.
- `mem_rvalid_i` input, 1: memory read response valid.
- `mem_rdata_i` input, 32: word-aligned read data.
- `mem_err_i` input, 1: bus error on this response.
- `load_valid_o` output, 1: aligned load result valid. One-cycle pulse per response.
- `load_data_o` output, 32: aligned and extended data.
- `load_tag_o` output, `TAG_W`: tag of the completed load.
- `load_err_o` output, 1: completed load faulted.
- `pending_o` output, `$clog2(DEPTH+1)`: number of outstanding loads.
- `resp_unexpected_o` output, 1: one-cycle pulse when a response arrives with nothing outstanding.

## Operation
- **Push:** occurs when `req_valid_i && req_ready_o`. Stores {width, unsigned, byte_idx, tag} at the write pointer.
  - `req_valid_i` while not ready: the request is dropped and no state changes. The upstream stall guarantees this does not happen in the system; the bench still checks it.
- **Pop:** occurs when `mem_rvalid_i && pending_o != 0`. Uses the entry at the read pointer, processes the response, and advances the pointer.
- **Pointers:** `log2(DEPTH)+1` bits wide, with natural wrap-around. Full is detected by MSB differ / rest equal; empty by pointers equal. `pending_o` is the registered count.
- **Same-cycle push and pop:** both take effect and the count is unchanged.
  - When full, `req_ready_o` is computed from the pre-pop count, so the push is refused that cycle.
  - When empty, the push is not visible to the pop. A response needs an entry that is already stored.
- **Alignment:** `shifted = mem_rdata_i >> (8*byte_idx)`.
  - `BYTE`: `{24{ext}, shifted[7:0]}` where `ext = !unsigned & shifted[7]`.
  - `HALF`: `{16{ext}, shifted[15:0]}` where `ext = !unsigned & shifted[15]`. `byte_idx` is 0 or 2, since misaligned requests are rejected upstream.
  - `WORD`: `mem_rdata_i`. `byte_idx` is 0.
  - Any other width value: data = 0 and `load_err_o` = 1.
- **Error:** when `mem_err_i` = 1, `load_err_o` = 1 and `load_data_o` = 0. The entry is still popped and the tag is still returned.
- **Unexpected response:** `mem_rvalid_i` with an empty FIFO gives `resp_unexpected_o` = 1 for one cycle. There is no pop and no `load_valid_o`.

## Timing
- Memory response latency is at least 1 cycle after the request push.
- The block adds 1 cycle: a response at edge N produces `load_valid_o`/`load_data_o`/`load_tag_o`/`load_err_o` valid after edge N+1, registered.
- `load_valid_o` and `resp_unexpected_o` are registered pulses. `load_data_o`, `load_tag_o` and `load_err_o` hold their last value when `load_valid_o` = 0.
- Sustained throughput is 1 push and 1 pop per cycle.
- `req_ready_o` is combinational from registered state only.
- **Reset (`rstn_i` low, any time, asynchronous):** pointers = 0 and `pending_o` = 0. `load_valid_o`, `load_data_o`, `load_tag_o`, `load_err_o` and `resp_unexpected_o` = 0. `req_ready_o` = 1.
  - In-flight loads are discarded.
  - A response arriving after reset deassertion flags `resp_unexpected_o`.

## Test plan
- **Byte extension:** push {BYTE, signed, idx 3, tag 7}, then respond `mem_rdata_i` = 32'h80_12_34_56.
  - Next cycle: `load_data_o` = 32'hFFFF_FF80, `load_tag_o` = 7.
  - Repeat with unsigned: `load_data_o` = 32'h0000_0080.
- **Halfword and word:** push {HALF, signed, idx 2, tag 3}, then {WORD, idx 0, tag 4}. Respond 32'h8001_7FFF then 32'hDEAD_BEEF.
  - Results in order: 32'hFFFF_8001 / tag 3, then 32'hDEAD_BEEF / tag 4.
- **Fill and refuse:** push DEPTH=4 loads with no responses.
  - `pending_o` = 4 and `req_ready_o` = 0.
  - A 5th `req_valid_i` is ignored.
  - Four responses then return tags in push order, and `pending_o` reaches 0.
- **Simultaneous events and wrap-around:** 10 cycles of push+pop back-to-back at count 1.
  - `pending_o` stays 1 and tags return in order across the pointer wrap.
  - Push+pop at full gives `pending_o` 4 → 3.
- **Error and unexpected response:**
  - Respond with `mem_err_i` = 1 to a tag-9 load: `load_err_o` = 1, data 0, tag 9.
  - `mem_rvalid_i` with the FIFO empty: `resp_unexpected_o` pulses for 1 cycle and `load_valid_o` stays 0.
- **Reset mid-operation:** with 3 loads pending, assert `rstn_i` low between clock edges.
  - Outputs go to 0 immediately and `pending_o` = 0.
  - After release, a response gives `resp_unexpected_o` = 1.

Source files
------------

// File: rtl/mem_load_align.sv
// mem_load_align: in-order load metadata FIFO plus response alignment and
// sign/zero extension. Results are registered one cycle after the response.

package mem_load_align_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_e;
endpackage

module mem_load_align
    import mem_load_align_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       req_valid_i,
    input  mem_width_e                 req_width_i,
    input  logic                       req_unsigned_i,
    input  logic [1:0]                 req_byte_idx_i,
    input  logic [TAG_W-1:0]           req_tag_i,
    output logic                       req_ready_o,
    input  logic                       mem_rvalid_i,
    input  logic [31:0]                mem_rdata_i,
    input  logic                       mem_err_i,
    output logic                       load_valid_o,
    output logic [31:0]                load_data_o,
    output logic [TAG_W-1:0]           load_tag_o,
    output logic                       load_err_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic                       resp_unexpected_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    mem_width_e       width_mem    [DEPTH];
    logic             unsigned_mem [DEPTH];
    logic [1:0]       byte_idx_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem      [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             push;
    logic             pop;
    logic             fifo_empty;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    mem_width_e       rd_width;
    logic             rd_unsigned;
    logic [1:0]       rd_byte_idx;
    logic [TAG_W-1:0] rd_tag;

    logic [15:0]      shifted;
    logic             ext;
    logic [31:0]      aligned;
    logic             bad_width;

    assign fifo_empty  = (count_q == '0);
    assign req_ready_o = (count_q != FULL_CNT);
    assign push        = req_valid_i && req_ready_o;
    // A same-cycle push into an empty FIFO is not visible to this pop.
    assign pop         = mem_rvalid_i && !fifo_empty;
    assign pending_o   = count_q;

    assign wr_idx      = wr_ptr_q[IDX_W-1:0];
    assign rd_idx      = rd_ptr_q[IDX_W-1:0];
    assign rd_width    = width_mem[rd_idx];
    assign rd_unsigned = unsigned_mem[rd_idx];
    assign rd_byte_idx = byte_idx_mem[rd_idx];
    assign rd_tag      = tag_mem[rd_idx];

    // Metadata storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        if (push) begin
            width_mem[wr_idx]    <= req_width_i;
            unsigned_mem[wr_idx] <= req_unsigned_i;
            byte_idx_mem[wr_idx] <= req_byte_idx_i;
            tag_mem[wr_idx]      <= req_tag_i;
        end
    end

    // Pointers and occupancy count; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Extract the addressed lane and extend it to 32 bits.
    always_comb begin
        shifted   = 16'(mem_rdata_i >> {rd_byte_idx, 3'b000});
        ext       = 1'b0;
        aligned   = '0;
        bad_width = 1'b0;
        case (rd_width)
            BYTE: begin
                ext     = !rd_unsigned && shifted[7];
                aligned = {{24{ext}}, shifted[7:0]};
            end
            HALF: begin
                ext     = !rd_unsigned && shifted[15];
                aligned = {{16{ext}}, shifted[15:0]};
            end
            WORD: begin
                aligned = mem_rdata_i;
            end
            default: begin
                bad_width = 1'b1;
            end
        endcase
    end

    // Registered result; data/tag/err hold between completions.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            load_valid_o      <= 1'b0;
            load_data_o       <= '0;
            load_tag_o        <= '0;
            load_err_o        <= 1'b0;
            resp_unexpected_o <= 1'b0;
        end else begin
            load_valid_o      <= pop;
            resp_unexpected_o <= mem_rvalid_i && fifo_empty;
            if (pop) begin
                load_tag_o  <= rd_tag;
                load_err_o  <= mem_err_i || bad_width;
                load_data_o <= (mem_err_i || bad_width) ? '0 : aligned;
            end
        end
    end

endmodule
